// File: rtl/uart_param.sv
// Parametrised UART: run-time baud divisor, configurable frame format, RX FIFO and
// sticky error reporting. Single sys_clk domain; the rx pin is synchronised locally.
module uart_param #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned RX_FIFO_AW = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [DATA_BITS-1:0] out_data,
  input  logic                 wr,
  output logic                 tx,
  output logic                 tx_empty,
  output logic                 tx_ov,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] in_data,
  input  logic                 rd,
  output logic                 rx_empty,
  output logic                 rx_ov,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 err_clr
);

  localparam int          Depth     = 2 ** RX_FIFO_AW;
  localparam int unsigned PtrW      = RX_FIFO_AW + 1;
  localparam logic [2:0]  LastData  = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LastStop  = 3'(STOP_BITS - 1);
  localparam logic        ParOdd    = (PARITY == 1);
  localparam logic        HasParity = (PARITY != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_e                 tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0]   tx_div_q, tx_div_d;
  logic [DIV_WIDTH-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]             tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_q, tx_d;
  logic                   tx_empty_q;
  logic                   tx_ov_q, tx_ov_d;
  logic                   tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - DIV_WIDTH'(1));

  // TX next-state: each state lasts one bit period; tx_d is the level of the next bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_ov_d    = tx_ov_q;

    if (tx_state_q != StIdle) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + DIV_WIDTH'(1);
    end

    unique case (tx_state_q)
      StIdle: begin
        if (wr) begin
          tx_state_d = StStart;
          tx_div_d   = divisor;
          tx_shift_d = out_data;
          tx_par_d   = (^out_data) ^ ParOdd;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_ov_d    = 1'b0;
        end
      end
      StStart: begin
        if (tx_bit_end) begin
          tx_state_d = StData;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      StData: begin
        if (tx_bit_end) begin
          if (tx_idx_q == LastData) begin
            tx_idx_d = '0;
            if (HasParity) begin
              tx_state_d = StParity;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = StStop;
              tx_d       = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_d[0];
          end
        end
      end
      StParity: begin
        if (tx_bit_end) begin
          tx_state_d = StStop;
          tx_idx_d   = '0;
          tx_d       = 1'b1;
        end
      end
      StStop: begin
        if (tx_bit_end) begin
          if (tx_idx_q == LastStop) begin
            tx_state_d = StIdle;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
          tx_d = 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase

    // A write while busy is dropped and flagged.
    if (wr && (tx_state_q != StIdle)) begin
      tx_ov_d = 1'b1;
    end
  end

  // TX state and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_q <= StIdle;
      tx_div_q   <= '0;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_empty_q <= 1'b1;
      tx_ov_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_empty_q <= (tx_state_d == StIdle);
      tx_ov_q    <= tx_ov_d;
    end
  end

  assign tx       = tx_q;
  assign tx_empty = tx_empty_q;
  assign tx_ov    = tx_ov_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  state_e               rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_div_q, rx_div_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [DIV_WIDTH-1:0] rx_target;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_sample;
  logic                 rx_push;
  logic                 frame_evt;
  logic                 parity_evt;

  // Start state waits half a bit to land mid-bit; later states wait a full bit.
  assign rx_target = (rx_state_q == StStart) ? (rx_div_q >> 1) - DIV_WIDTH'(1)
                                             : rx_div_q - DIV_WIDTH'(1);
  assign rx_sample = (rx_cnt_q == rx_target);

  // Two-flop synchroniser plus previous-value register for falling-edge detect.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX next-state: sample each bit, push at the stop-bit sample.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;

    if (rx_state_q != StIdle) begin
      rx_cnt_d = rx_sample ? '0 : rx_cnt_q + DIV_WIDTH'(1);
    end

    unique case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = StStart;
          rx_div_d   = divisor;
          rx_cnt_d   = '0;
        end
      end
      StStart: begin
        if (rx_sample) begin
          if (rx_sync_q) begin
            rx_state_d = StIdle;  // glitch, not a real start bit
          end else begin
            rx_state_d = StData;
            rx_idx_d   = '0;
            rx_par_d   = 1'b0;
            rx_perr_d  = 1'b0;
          end
        end
      end
      StData: begin
        if (rx_sample) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_par_d   = rx_par_q ^ rx_sync_q;
          if (rx_idx_q == LastData) begin
            rx_state_d = HasParity ? StParity : StStop;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (rx_sample) begin
          rx_perr_d  = ((rx_par_q ^ rx_sync_q) != ParOdd);
          rx_state_d = StStop;
        end
      end
      StStop: begin
        if (rx_sample) begin
          rx_push    = 1'b1;
          frame_evt  = !rx_sync_q;
          parity_evt = rx_perr_q;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // RX FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state_q <= StIdle;
      rx_div_q   <= '0;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (first-word fall-through) and sticky error flags
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic                 fifo_full, fifo_empty;
  logic                 pop, push_ok, ov_evt;
  logic                 rx_empty_q;
  logic                 rx_ov_q, rx_frame_err_q, rx_parity_err_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[RX_FIFO_AW] != rd_ptr_q[RX_FIFO_AW]) &&
                      (wr_ptr_q[RX_FIFO_AW-1:0] == rd_ptr_q[RX_FIFO_AW-1:0]);
  assign pop        = rd && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok    = rx_push && (!fifo_full || pop);
  assign ov_evt     = rx_push && fifo_full && !pop;
  assign wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

  // FIFO storage, pointers and sticky flags (a new event beats err_clr).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      rx_empty_q      <= 1'b1;
      rx_ov_q         <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[RX_FIFO_AW-1:0]] <= rx_shift_q;
      end
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      rx_empty_q      <= (wr_ptr_d == rd_ptr_d);
      rx_ov_q         <= ov_evt | (rx_ov_q & ~err_clr);
      rx_frame_err_q  <= frame_evt | (rx_frame_err_q & ~err_clr);
      rx_parity_err_q <= parity_evt | (rx_parity_err_q & ~err_clr);
    end
  end

  assign in_data       = mem_q[rd_ptr_q[RX_FIFO_AW-1:0]];
  assign rx_empty      = rx_empty_q;
  assign rx_ov         = rx_ov_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_parity_err = rx_parity_err_q;

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised UART for the SoC peripheral bus, in the single `sys_clk` domain. It extends the fixed 8N1, fixed-baud UART with the following features:
- a run-time baud divisor;
- configurable data bits, parity and stop bits;
- an RX FIFO;
- RX framing and parity error reporting.

Host-side strobes (`wr`, `rd`) are single-cycle. The serial pins connect directly to pads.

## Interface
Parameters:
- DIV_WIDTH, 16: width of the `divisor` input.
- DATA_BITS, 8: data bits per frame. Legal range is 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: TX stop bits. Legal values are 1 or 2. RX checks only the first stop bit.
- RX_FIFO_AW, 2: RX FIFO address width. Depth is 2^RX_FIFO_AW.

Ports:
- sys_clk  in  1  clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- divisor  in  DIV_WIDTH  bit period in sys_clk cycles. Must be >= 4. Sampled at the start of each frame.
- out_data  in  DATA_BITS  TX data. Captured when `wr` is high.
- wr  in  1  TX load strobe.
- tx  out  1  serial output. Idle level is 1.
- tx_empty  out  1  transmitter idle, ready to accept `wr`.
- tx_ov  out  1  sticky: `wr` arrived while busy.
- rx  in  1  serial input. Asynchronous; synchronised internally.
- in_data  out  DATA_BITS  RX FIFO head word (first-word fall-through).
- rd  in  1  pop the RX FIFO.
- rx_empty  out  1  RX FIFO empty.
- rx_ov  out  1  sticky: a received word was dropped because the FIFO was full.
- rx_frame_err  out  1  sticky: stop bit sampled as 0.
- rx_parity_err  out  1  sticky: parity mismatch.
- err_clr  in  1  clears `rx_ov`, `rx_frame_err` and `rx_parity_err`.

## Operation
Reset values (asynchronous, while `sys_rst_n` = 0):
- tx = 1, tx_empty = 1, tx_ov = 0.
- rx_empty = 1, in_data = 0.
- All error flags = 0, FIFO pointers = 0.
- Both FSMs in IDLE, all counters 0.

TX frame:
- Bit order: start bit (0), DATA_BITS data bits LSB first, parity bit if PARITY != 0, then STOP_BITS ones.
- Odd parity: the parity bit makes the total count of ones over data + parity odd. Even parity: makes it even.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- `wr` in IDLE: capture `out_data` and `divisor`, clear `tx_ov`, go to START.
- `wr` in any other state: data is dropped and `tx_ov` is set to 1.
- Each state holds for exactly one bit period of `divisor` cycles per bit.
- After the last stop bit the FSM returns to IDLE.

RX front end:
- 2-flop synchroniser on `rx`.
- Falling edge (previous sync = 1, current = 0) in IDLE: go to START and latch `divisor`.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- Bit counter runs in all non-IDLE states.
- First sample is taken floor(div/2) cycles after edge detection; each following sample is taken div cycles later.
- Start bit sampled as 1 (glitch): return to IDLE, no flags, no push.
- At the stop-bit sample, push the word to the FIFO. A frame error or parity error sets the corresponding flag; the word is still pushed.
- Return to IDLE in the cycle after the stop-bit sample. The next falling edge is accepted from that cycle on.

RX FIFO:
- `rd` when empty: ignored.
- Push when full: word dropped, `rx_ov` set to 1.
- Push and `rd` in the same cycle while full: both happen, no overrun.
- `err_clr` and a new error event in the same cycle: the set wins.

## Timing
- `wr` at cycle 0 (IDLE): `tx_empty` = 0 and `tx` = 0 from cycle 1.
- Frame length: N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits, total N·div cycles.
- `tx_empty` returns to 1 at cycle N·div + 1. A `wr` in that same cycle is accepted.
- All outputs are registered. `tx` has no combinational path from `wr`.
- RX: the FIFO push is visible 1 cycle after the stop-bit sample: `rx_empty` falls and `in_data` is valid.
- `rd` at cycle t: `in_data` shows the next word and `rx_empty` updates at t+1.
- `divisor` changes mid-frame do not affect the current frame.
- RX pin-to-edge-detect latency: 2 cycles from synchroniser input.

## Test plan
- Reset: assert `sys_rst_n` = 0 mid-TX and mid-RX frame. Required: `tx` = 1 immediately; all flags 0 and `rx_empty` = 1; the next frame after release is correct.
- TX 0xA5, DATA_BITS = 8, PARITY = 2 (even), STOP_BITS = 1, div = 16:
  - `tx` = 0 for 16 cycles;
  - then bits 1,0,1,0,0,1,0,1;
  - then parity 0, then stop 1;
  - `tx_empty` = 1 at cycle 177.
  - A second `wr` at cycle 50 sets `tx_ov` and does not disturb the frame.
- Loopback `tx` -> `rx`, div = 5, bytes 0x00, 0xFF, 0x3C. Required: FIFO yields the same bytes in order, no error flags.
- FIFO depth 4: receive 5 frames without `rd`. Required: `rx_ov` = 1 after frame 5; four `rd`s return frames 1–4; then `rx_empty` = 1.
- Protocol errors:
  - drive a frame with stop bit 0 -> `rx_frame_err` = 1, word pushed;
  - drive a frame with wrong parity -> `rx_parity_err` = 1;
  - `err_clr` clears both flags.
- Glitch: `rx` low for 3 cycles at div = 16. Required: no push, no flags, RX back in IDLE.
